// File: rtl/parking_gate_arbiter.sv
// Shared parking barrier arbiter: exit beats entries, entries round-robin; all outputs registered.
// Latency: request -> grant/gate_open in 1 cycle; shortest transaction is 4 cycles; requests are sampled only in IDLE.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 10,
    parameter int OPEN_TIMEOUT = 15
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       req_in0,
    input  logic       req_in1,
    input  logic       req_out,
    input  logic       pass,
    output logic [2:0] grant,
    output logic       gate_open,
    output logic [3:0] count,
    output logic       full,
    output logic       timeout_evt
);

    typedef enum logic [1:0] {IDLE, OPEN, PASSING, COMMIT} state_t;

    localparam logic [3:0] CAP  = 4'(CAPACITY);
    localparam logic [7:0] TMAX = 8'(OPEN_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [2:0] grant_nx;
    logic       gate_nx;
    logic [3:0] count_nx;
    logic       tevt_nx;
    logic       ptr, ptr_nx;
    logic [7:0] timer, timer_nx;

    logic elig_out, elig_in0, elig_in1;

    assign elig_out = req_out && (count != 4'd0);
    assign elig_in0 = req_in0 && (count < CAP);
    assign elig_in1 = req_in1 && (count < CAP);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        gate_nx  = gate_open;
        count_nx = count;
        tevt_nx  = 1'b0;
        ptr_nx   = ptr;
        timer_nx = timer;

        case (state)
            IDLE: begin
                grant_nx = 3'b000;
                gate_nx  = 1'b0;
                if (elig_out)
                    grant_nx = 3'b100;
                else if (elig_in0 && elig_in1)
                    grant_nx = ptr ? 3'b010 : 3'b001;
                else if (elig_in0)
                    grant_nx = 3'b001;
                else if (elig_in1)
                    grant_nx = 3'b010;

                if (grant_nx != 3'b000) begin
                    state_nx = OPEN;
                    gate_nx  = 1'b1;
                    timer_nx = 8'd0;
                end
            end

            OPEN: begin
                // A passage seen on the expiry cycle still counts as a passage.
                if (pass) begin
                    state_nx = PASSING;
                end else if (timer == TMAX) begin
                    state_nx = IDLE;
                    grant_nx = 3'b000;
                    gate_nx  = 1'b0;
                    tevt_nx  = 1'b1;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end

            PASSING: begin
                if (!pass) begin
                    state_nx = COMMIT;
                    gate_nx  = 1'b0;
                end
            end

            COMMIT: begin
                // Saturating update even though eligibility already bounds count.
                if (grant[2]) begin
                    if (count != 4'd0)
                        count_nx = count - 4'd1;
                end else if (grant[1:0] != 2'b00) begin
                    if (count < CAP)
                        count_nx = count + 4'd1;
                    ptr_nx = ~ptr;
                end
                state_nx = IDLE;
                grant_nx = 3'b000;
                gate_nx  = 1'b0;
            end

            default: begin
                state_nx = IDLE;
                grant_nx = 3'b000;
                gate_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 3'b000;
            gate_open   <= 1'b0;
            count       <= 4'd0;
            full        <= 1'b0;
            timeout_evt <= 1'b0;
            ptr         <= 1'b0;
            timer       <= 8'd0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            gate_open   <= gate_nx;
            count       <= count_nx;
            full        <= (count_nx == CAP);
            timeout_evt <= tevt_nx;
            ptr         <= ptr_nx;
            timer       <= timer_nx;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter with CAPACITY=10, OPEN_TIMEOUT=15.
module tb_parking_gate_arbiter;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       req_in0, req_in1, req_out, pass;
    logic [2:0] grant;
    logic       gate_open;
    logic [3:0] count;
    logic       full;
    logic       timeout_evt;

    parking_gate_arbiter #(.CAPACITY(10), .OPEN_TIMEOUT(15)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .req_in0     (req_in0),
        .req_in1     (req_in1),
        .req_out     (req_out),
        .pass        (pass),
        .grant       (grant),
        .gate_open   (gate_open),
        .count       (count),
        .full        (full),
        .timeout_evt (timeout_evt)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       rst;
        logic       i0;
        logic       i1;
        logic       o;
        logic       p;
        logic [2:0] g;
        logic       gate;
        logic [3:0] cnt;
        logic       tevt;
    } vec_t;

    vec_t  tbl[$];
    vec_t  exp_q[$];
    int    tests  = 0;
    int    failed = 0;
    int    vec_no = 0;
    string phase  = "";

    function automatic vec_t mkv(input logic rst, input logic i0, input logic i1,
                                 input logic o, input logic p, input logic [2:0] g,
                                 input logic gate, input int cnt, input logic tevt);
        vec_t v;
        v.rst  = rst;
        v.i0   = i0;
        v.i1   = i1;
        v.o    = o;
        v.p    = p;
        v.g    = g;
        v.gate = gate;
        v.cnt  = 4'(cnt);
        v.tevt = tevt;
        return v;
    endfunction

    // One full transaction: grant edge, pass high, pass low (COMMIT), back to IDLE.
    task automatic add_txn(input logic i0, input logic i1, input logic o,
                           input logic [2:0] g, input int cnt_before);
        int after;
        after = g[2] ? cnt_before - 1 : cnt_before + 1;
        tbl.push_back(mkv(0, i0, i1, o, 0, g, 1, cnt_before, 0));
        tbl.push_back(mkv(0, i0, i1, o, 1, g, 1, cnt_before, 0));
        tbl.push_back(mkv(0, i0, i1, o, 0, g, 0, cnt_before, 0));
        tbl.push_back(mkv(0, i0, i1, o, 0, 3'b000, 0, after, 0));
    endtask

    task automatic check_out();
        vec_t e;
        logic exp_full;
        e = exp_q.pop_front();
        exp_full = (e.cnt == 4'd10);
        tests++;
        if (grant !== e.g || gate_open !== e.gate || count !== e.cnt ||
            full !== exp_full || timeout_evt !== e.tevt) begin
            failed++;
            $display("FAIL %s #%0d: got grant=%b gate=%b count=%0d full=%b tevt=%b, want grant=%b gate=%b count=%0d full=%b tevt=%b",
                     phase, vec_no, grant, gate_open, count, full, timeout_evt,
                     e.g, e.gate, e.cnt, exp_full, e.tevt);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_2);
        reset   = v.rst;
        req_in0 = v.i0;
        req_in1 = v.i1;
        req_out = v.o;
        pass    = v.p;
        exp_q.push_back(v);
        @(posedge clk_2);
        #1;
        check_out();
        vec_no++;
    endtask

    task automatic run_tbl(input string name);
        phase  = name;
        vec_no = 0;
        foreach (tbl[k]) apply(tbl[k]);
        tbl.delete();
    endtask

    initial begin
        reset   = 1'b1;
        req_in0 = 1'b0;
        req_in1 = 1'b0;
        req_out = 1'b0;
        pass    = 1'b0;

        // Round-robin between both entry lanes held high.
        tbl.push_back(mkv(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        add_txn(1, 1, 0, 3'b001, 0);
        add_txn(1, 1, 0, 3'b010, 1);
        add_txn(1, 1, 0, 3'b001, 2);
        add_txn(1, 1, 0, 3'b010, 3);
        run_tbl("round_robin");

        // Exit ignored while empty, then exit beats a concurrent entry.
        tbl.push_back(mkv(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 0, 3'b000, 0, 0, 0));
        add_txn(1, 0, 0, 3'b001, 0);
        add_txn(1, 0, 1, 3'b100, 1);
        run_tbl("exit_priority");

        // Fill to capacity, entry blocked, exit frees a slot, entry resumes.
        tbl.push_back(mkv(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        for (int k = 0; k < 10; k++) add_txn(1, 0, 0, 3'b001, k);
        tbl.push_back(mkv(0, 1, 0, 0, 0, 3'b000, 0, 10, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 0, 3'b000, 0, 10, 0));
        add_txn(1, 0, 1, 3'b100, 10);
        add_txn(1, 0, 0, 3'b001, 9);
        run_tbl("full");

        // Single entry with a car on the sensor for three cycles.
        phase  = "single_entry";
        vec_no = 0;
        apply(mkv(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        apply(mkv(0, 1, 0, 0, 0, 3'b001, 1, 0, 0));
        apply(mkv(0, 0, 0, 0, 1, 3'b001, 1, 0, 0));
        apply(mkv(0, 0, 0, 0, 1, 3'b001, 1, 0, 0));
        apply(mkv(0, 0, 0, 0, 1, 3'b001, 1, 0, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b001, 0, 0, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b000, 0, 1, 0));

        // Timeout fires 15 cycles after the grant; count stays put.
        phase  = "timeout";
        vec_no = 0;
        apply(mkv(0, 1, 0, 0, 0, 3'b001, 1, 1, 0));
        for (int k = 0; k < 14; k++) apply(mkv(0, 0, 0, 0, 0, 3'b001, 1, 1, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
        apply(mkv(0, 0, 0, 0, 0, 3'b000, 0, 1, 0));

        // Pass arriving on the expiry cycle wins over the timeout.
        phase  = "pass_at_expiry";
        vec_no = 0;
        apply(mkv(0, 1, 0, 0, 0, 3'b001, 1, 1, 0));
        for (int k = 0; k < 14; k++) apply(mkv(0, 0, 0, 0, 0, 3'b001, 1, 1, 0));
        apply(mkv(0, 0, 0, 0, 1, 3'b001, 1, 1, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b001, 0, 1, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b000, 0, 2, 0));

        // Reset in the middle of PASSING discards the transaction.
        tbl.push_back(mkv(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        add_txn(1, 0, 0, 3'b001, 0);
        add_txn(1, 0, 0, 3'b001, 1);
        add_txn(1, 0, 0, 3'b001, 2);
        run_tbl("reset_prep");
        phase  = "reset_mid_passing";
        vec_no = 0;
        apply(mkv(0, 1, 0, 0, 0, 3'b001, 1, 3, 0));
        apply(mkv(0, 0, 0, 0, 1, 3'b001, 1, 3, 0));
        apply(mkv(1, 0, 0, 0, 1, 3'b000, 0, 0, 0));
        apply(mkv(0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        apply(mkv(0, 0, 1, 0, 0, 3'b010, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
